// File: rtl/cpu_pkg.sv
// Shared datapath constants for the lab CPU: widths and register indices.
package cpu_pkg;

   localparam int unsigned DATA_W   = 8;
   localparam int unsigned ADDR_W   = 2;
   localparam int unsigned NUM_REGS = 2 ** ADDR_W;

   typedef logic [ADDR_W-1:0] reg_idx_t;

   localparam reg_idx_t R0 = 2'd0;
   localparam reg_idx_t R1 = 2'd1;
   localparam reg_idx_t R2 = 2'd2;
   localparam reg_idx_t R3 = 2'd3;

endpackage

// File: rtl/rf_read_port.sv
// One register-file read port: array lookup with write-back stage bypass.
module rf_read_port #(
   parameter int unsigned DATA_W   = cpu_pkg::DATA_W,
   parameter int unsigned ADDR_W   = cpu_pkg::ADDR_W,
   parameter int unsigned NUM_REGS = 2 ** ADDR_W,
   parameter bit          ZERO_R0  = 1'b0
) (
   input  logic [ADDR_W-1:0]                 idx,
   input  logic [NUM_REGS-1:0][DATA_W-1:0]   arr,
   input  logic                              wb_valid,
   input  logic [ADDR_W-1:0]                 wb_addr,
   input  logic [DATA_W-1:0]                 wb_data,
   output logic [DATA_W-1:0]                 data_c
);
   import cpu_pkg::*;

   // Pending write wins over the array; hardwired r0 wins over everything.
   always_comb begin
      data_c = arr[idx];
      if (wb_valid && (wb_addr == idx)) begin
         data_c = wb_data;
      end
      if (ZERO_R0 && (idx == ADDR_W'(R0))) begin
         data_c = '0;
      end
   end

endmodule

// File: rtl/register_file.sv
// Lab CPU register file: two operand read ports, one write-back staged write,
// and a registered debug read port for the board display.
module register_file #(
   parameter int unsigned DATA_W   = cpu_pkg::DATA_W,
   parameter int unsigned ADDR_W   = cpu_pkg::ADDR_W,
   parameter int unsigned NUM_REGS = 2 ** ADDR_W,
   parameter bit          ZERO_R0  = 1'b0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] read_reg1,
   input  logic [ADDR_W-1:0] read_reg2,
   input  logic              reg_write,
   input  logic [ADDR_W-1:0] write_reg,
   input  logic [DATA_W-1:0] write_data,
   output logic [DATA_W-1:0] readdata1,
   output logic [DATA_W-1:0] readdata2,
   input  logic [ADDR_W-1:0] dbg_sel,
   output logic [DATA_W-1:0] dbg_data,
   output logic              wb_pending
);
   import cpu_pkg::*;

   logic [NUM_REGS-1:0][DATA_W-1:0] arr;
   logic                            wb_valid;
   logic [ADDR_W-1:0]               wb_addr;
   logic [DATA_W-1:0]               wb_data;
   logic                            capture_c;
   logic [DATA_W-1:0]               dbg_c;

   // Writes to r0 are dropped at capture when r0 is hardwired to zero.
   always_comb begin
      capture_c = reg_write;
      if (ZERO_R0 && (write_reg == ADDR_W'(R0))) begin
         capture_c = 1'b0;
      end
   end

   // Write-back stage capture, array commit and debug register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         arr      <= '0;
         wb_valid <= 1'b0;
         wb_addr  <= '0;
         wb_data  <= '0;
         dbg_data <= '0;
      end else begin
         if (wb_valid) begin
            arr[wb_addr] <= wb_data;
         end
         wb_valid <= capture_c;
         if (capture_c) begin
            wb_addr <= write_reg;
            wb_data <= write_data;
         end
         dbg_data <= dbg_c;
      end
   end

   assign wb_pending = wb_valid;

   rf_read_port #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .ZERO_R0(ZERO_R0)
   ) u_port1 (
      .idx(read_reg1), .arr(arr), .wb_valid(wb_valid),
      .wb_addr(wb_addr), .wb_data(wb_data), .data_c(readdata1)
   );

   rf_read_port #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .ZERO_R0(ZERO_R0)
   ) u_port2 (
      .idx(read_reg2), .arr(arr), .wb_valid(wb_valid),
      .wb_addr(wb_addr), .wb_data(wb_data), .data_c(readdata2)
   );

   rf_read_port #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .ZERO_R0(ZERO_R0)
   ) u_port_dbg (
      .idx(dbg_sel), .arr(arr), .wb_valid(wb_valid),
      .wb_addr(wb_addr), .wb_data(wb_data), .data_c(dbg_c)
   );

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file; two instances (r0 ordinary / r0 hardwired)
// share one stimulus stream.
module tb_register_file;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] read_reg1, read_reg2, write_reg, dbg_sel;
   logic       reg_write;
   logic [7:0] write_data;

   logic [7:0] rd1_0, rd2_0, dbg_0;
   logic       pend_0;
   logic [7:0] rd1_1, rd2_1, dbg_1;
   logic       pend_1;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   register_file #(.ZERO_R0(1'b0)) u_rf0 (
      .clk(clk), .reset(reset), .read_reg1(read_reg1), .read_reg2(read_reg2),
      .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
      .readdata1(rd1_0), .readdata2(rd2_0), .dbg_sel(dbg_sel),
      .dbg_data(dbg_0), .wb_pending(pend_0)
   );

   register_file #(.ZERO_R0(1'b1)) u_rf1 (
      .clk(clk), .reset(reset), .read_reg1(read_reg1), .read_reg2(read_reg2),
      .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
      .readdata1(rd1_1), .readdata2(rd2_1), .dbg_sel(dbg_sel),
      .dbg_data(dbg_1), .wb_pending(pend_1)
   );

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge; inputs and checks happen mid-cycle.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset      = 1'b1;
      read_reg1  = 2'd0;
      read_reg2  = 2'd0;
      write_reg  = 2'd0;
      dbg_sel    = 2'd1;
      reg_write  = 1'b0;
      write_data = 8'h00;
      tick();
      tick();
      reset = 1'b0;

      // 1: reset while a write is staged clears everything immediately
      read_reg1 = 2'd1; read_reg2 = 2'd1;
      reg_write = 1'b1; write_reg = 2'd1; write_data = 8'h77;
      tick();
      tick();
      reg_write = 1'b0;
      check("pre_rst_rd1", rd1_0, 8'h77);
      check("pre_rst_pend", 8'(pend_0), 8'h01);
      check("pre_rst_dbg", dbg_0, 8'h77);
      #2 reset = 1'b1;
      #1;
      check("rst_rd1", rd1_0, 8'h00);
      check("rst_rd2", rd2_0, 8'h00);
      check("rst_dbg", dbg_0, 8'h00);
      check("rst_pend", 8'(pend_0), 8'h00);
      check("rst_rd1_z", rd1_1, 8'h00);
      tick();
      reset = 1'b0;
      tick();
      check("post_rst_rd1", rd1_0, 8'h00);
      check("post_rst_pend", 8'(pend_0), 8'h00);

      // 2: write r2=5A, bypass after edge 1, committed after edge 2
      read_reg1 = 2'd2;
      reg_write = 1'b1; write_reg = 2'd2; write_data = 8'h5A;
      #1;
      check("w2_same_cycle", rd1_0, 8'h00);
      tick();
      reg_write = 1'b0;
      check("w2_bypass", rd1_0, 8'h5A);
      check("w2_pend", 8'(pend_0), 8'h01);
      check("w2_pend_z", 8'(pend_1), 8'h01);
      tick();
      check("w2_array", rd1_0, 8'h5A);
      check("w2_pend_clr", 8'(pend_0), 8'h00);
      check("w2_array_z", rd1_1, 8'h5A);

      // 3: r1=10 committed, then same-cycle read while writing r1=33
      reg_write = 1'b1; write_reg = 2'd1; write_data = 8'h10;
      tick();
      reg_write = 1'b0;
      tick();
      read_reg2 = 2'd1;
      reg_write = 1'b1; write_reg = 2'd1; write_data = 8'h33;
      #1;
      check("r1_old", rd2_0, 8'h10);
      tick();
      reg_write = 1'b0;
      check("r1_new", rd2_0, 8'h33);
      tick();
      check("r1_commit", rd2_0, 8'h33);

      // 4: back-to-back writes to r3, later value wins
      read_reg1 = 2'd3; read_reg2 = 2'd3;
      reg_write = 1'b1; write_reg = 2'd3; write_data = 8'h01;
      tick();
      check("r3_w1", rd1_0, 8'h01);
      write_data = 8'h02;
      tick();
      check("r3_w2", rd1_0, 8'h02);
      check("r3_w2_p2", rd2_0, 8'h02);
      write_data = 8'h03;
      tick();
      check("r3_w3", rd1_0, 8'h03);
      reg_write = 1'b0;
      tick();
      check("r3_final", rd1_0, 8'h03);
      check("r3_final_pend", 8'(pend_0), 8'h00);
      check("r3_final_p2", rd2_0, 8'h03);

      // 5: write r0=FF; ordinary r0 keeps it, hardwired r0 reads 0
      read_reg1 = 2'd0; read_reg2 = 2'd0;
      reg_write = 1'b1; write_reg = 2'd0; write_data = 8'hFF;
      tick();
      reg_write = 1'b0;
      check("r0_byp_rd1", rd1_0, 8'hFF);
      check("r0_byp_rd2", rd2_0, 8'hFF);
      check("r0z_pend", 8'(pend_1), 8'h00);
      check("r0z_byp_rd1", rd1_1, 8'h00);
      check("r0z_byp_rd2", rd2_1, 8'h00);
      tick();
      check("r0_arr_rd1", rd1_0, 8'hFF);
      check("r0_arr_rd2", rd2_0, 8'hFF);
      check("r0z_arr_rd1", rd1_1, 8'h00);
      check("r0z_arr_rd2", rd2_1, 8'h00);

      // 6: debug port lags readdata by one edge
      read_reg1 = 2'd1;
      reg_write = 1'b1; write_reg = 2'd1; write_data = 8'hA5;
      tick();
      reg_write = 1'b0;
      check("dbg_rd1", rd1_0, 8'hA5);
      check("dbg_lag", dbg_0, 8'h33);
      tick();
      check("dbg_a5", dbg_0, 8'hA5);
      dbg_sel = 2'd3;
      #1;
      check("dbg_hold", dbg_0, 8'hA5);
      tick();
      check("dbg_r3", dbg_0, 8'h03);
      dbg_sel = 2'd0;
      tick();
      check("dbg_r0", dbg_0, 8'hFF);
      check("dbg_r0_z", dbg_1, 8'h00);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
